// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC / instruction fetch logic of the RV32IM core.
package npc_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } ifu_state_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_FAULT_WORD  = 32'h0000_0000;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC and keeps one request in flight to
// instruction memory. Each fetched word is handed to decode together with its
// PC over a valid/ready handshake. Execute-stage redirects squash in-flight
// work, and halt stops new requests from being issued.
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  ifu_state_t  r_state;
  logic [31:0] r_pc;
  logic        r_reqValid;
  logic [31:0] r_reqAddr;
  logic        r_squash;
  logic        r_instValid;
  logic [31:0] r_inst;
  logic [31:0] r_instPc;
  logic        r_instFault;

  logic [31:0] w_redirPc;
  logic [31:0] w_pcNext;
  logic        w_accept;

  // Redirect targets are forced to a word boundary by masking the low bits.
  assign w_redirPc = redirect_pc & ~32'h0000_0003;
  assign w_accept  = r_reqValid & imem_req_ready;

  // The next PC: a redirect wins over everything, then the decode handshake in
  // HOLD advances by one word (wrapping at 2^32), otherwise the PC holds.
  always_comb begin
    w_pcNext = r_pc;
    if (redirect_valid) begin
      w_pcNext = w_redirPc;
    end else if ((r_state == HOLD) && r_instValid && inst_ready) begin
      w_pcNext = r_pc + 32'd4;
    end
  end

  // Fetch FSM together with the request and decode-side output registers.
  // Entering REQ issues the next request straight away (unless halted) so the
  // best-case loop takes three cycles per instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= REQ;
      r_pc        <= RESET_PC;
      r_reqValid  <= 1'b0;
      r_reqAddr   <= RESET_PC;
      r_squash    <= 1'b0;
      r_instValid <= 1'b0;
      r_inst      <= INST_FAULT_WORD;
      r_instPc    <= RESET_PC;
      r_instFault <= 1'b0;
    end else begin
      r_pc <= w_pcNext;
      case (r_state)
        REQ: begin
          if (r_reqValid) begin
            if (w_accept) begin
              r_reqValid <= 1'b0;
              r_squash   <= 1'b0;
              r_state    <= (redirect_valid || r_squash) ? DROP : WAIT;
            end else if (redirect_valid) begin
              r_squash <= 1'b1;
            end
          end else if (!halt) begin
            r_reqValid <= 1'b1;
            r_reqAddr  <= w_pcNext;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (redirect_valid) begin
              r_state    <= REQ;
              r_reqValid <= !halt;
              r_reqAddr  <= w_pcNext;
            end else begin
              r_state     <= HOLD;
              r_instValid <= 1'b1;
              r_inst      <= imem_rsp_err ? INST_FAULT_WORD : imem_rsp_data;
              r_instFault <= imem_rsp_err;
              r_instPc    <= r_reqAddr;
            end
          end else if (redirect_valid) begin
            r_state <= DROP;
          end
        end
        HOLD: begin
          if (redirect_valid || inst_ready) begin
            r_instValid <= 1'b0;
            r_state     <= REQ;
            r_reqValid  <= !halt;
            r_reqAddr   <= w_pcNext;
          end
        end
        default: begin
          if (imem_rsp_valid) begin
            r_state    <= REQ;
            r_reqValid <= !halt;
            r_reqAddr  <= w_pcNext;
          end
        end
      endcase
    end
  end

  assign imem_req_valid = r_reqValid;
  assign imem_req_addr  = r_reqAddr;
  assign inst_valid     = r_instValid;
  assign inst           = r_inst;
  assign inst_pc        = r_instPc;
  assign inst_fault     = r_instFault;

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-issue RV32IM core: owns the program counter, fetches one 32-bit instruction at a time from instruction memory over a valid/ready request/response bus, and presents it with its PC to the decode stage over a valid/ready handshake. It is the producing end of the instruction interface consumed by the decoder. It accepts PC redirects from the execute stage for taken branches, `jal` and `jalr`, and a halt input driven when `ebreak` retires.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC of the first fetch after reset.
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_req_addr` output 32: fetch address, word aligned.
- `imem_rsp_valid` input 1: response valid, one cycle per accepted request.
- `imem_rsp_data` input 32: fetched instruction word.
- `imem_rsp_err` input 1: access fault for this response.
- `redirect_valid` input 1: execute stage overrides next PC.
- `redirect_pc` input 32: new PC. Bits [1:0] are ignored and forced to 0.
- `halt` input 1: stop issuing new fetches while high.
- `inst_valid` output 1: `inst`/`inst_pc` valid to decode.
- `inst_ready` input 1: decode accepts instruction.
- `inst` output 32: instruction word. Forced to 32'h0 on fault.
- `inst_pc` output 32: PC of `inst`.
- `inst_fault` output 1: fetch access fault for `inst`.

## Operation
- At most one outstanding memory request. Registered FSM with states REQ, WAIT, HOLD and DROP.
- **REQ**
  - `imem_req_valid`=1 with `imem_req_addr`=pc, unless `halt`=1.
  - On accept (valid&ready), go to WAIT.
  - Address and valid stay stable while valid&!ready.
- **WAIT**
  - On `imem_rsp_valid`, register data, err and pc into the output regs, then go to HOLD.
  - When err=1: `inst`=0 and `inst_fault`=1.
- **HOLD**
  - `inst_valid`=1.
  - On `inst_valid`&`inst_ready`: pc <= pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0). Go to REQ.
- **DROP**
  - Waits for the response of a squashed request.
  - On `imem_rsp_valid`, discard the response and go to REQ.
- **Redirect** (`redirect_valid`=1): pc <= `redirect_pc`. Effect by state:
  - REQ, request not accepted this cycle: stay in REQ. A request with `halt`=0 already in progress is kept stable until accepted, then the FSM goes to DROP.
  - REQ, request accepted this cycle: go to DROP.
  - WAIT without `imem_rsp_valid`: go to DROP.
  - WAIT with `imem_rsp_valid` in the same cycle: discard the response and go to REQ.
  - HOLD: clear `inst_valid` and go to REQ. This applies even if `inst_ready`=1 in the same cycle. Redirect wins, the handshake is void, and pc does not advance by 4.
  - DROP: update pc, stay in DROP.
- **Halt**
  - Gates only new request issue in REQ.
  - A request already presented (valid high, not yet accepted) stays until accepted.
  - WAIT, HOLD and DROP proceed normally.
- `imem_rsp_valid` in REQ or HOLD is a protocol error. It is ignored.

## Timing
- Reset values:
  - state=REQ, pc=`RESET_PC`.
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=0, `inst_pc`=`RESET_PC`, `inst_fault`=0.
- First `imem_req_valid`=1 in the first clock edge after `rst_n` rises (when `halt`=0).
- Response to decode latency: `inst_valid` rises the cycle after `imem_rsp_valid`.
- Decode handshake to next request: the next `imem_req_valid` is visible the cycle after the handshake.
- Best-case throughput, with a memory that is ready immediately and a 1-cycle response: one instruction per 3 cycles.
- `inst`, `inst_pc` and `inst_fault` are stable while `inst_valid`&!`inst_ready`.
- All outputs are registered. No combinational path from any input to any output.
- Reset asserted mid-operation: the state returns to reset values immediately (asynchronously). Any in-flight response arriving after reset is ignored because the FSM is in REQ.

## Structure
- Shared package `npc_pkg`:
  - `ifu_state_t` enum (REQ, WAIT, HOLD, DROP).
  - `PC_RESET_DEFAULT` = 32'h8000_0000.
  - `INST_FAULT_WORD` = 32'h0.
- No sub-module. PC register, FSM and output register live in one module.

## Test plan
- Reset, memory that is ready immediately with a 1-cycle response, decode always ready → fetch addresses 8000_0000, 8000_0004, 8000_0008. `inst_valid` pulses every 3 cycles with matching `inst_pc`.
- `imem_req_ready` held low 4 cycles → `imem_req_addr` and valid are stable for all 4 cycles, and there is a single accept.
- `redirect_valid` with `redirect_pc`=8000_0100 during WAIT → the pending response is dropped and never shown to decode. The next request address is 8000_0100.
- `redirect_valid` and `inst_ready` together in HOLD → `inst_valid` drops and the next address is the redirect target, not pc+4.
- `imem_rsp_err`=1 at 8000_0010 → `inst`=0, `inst_fault`=1, `inst_pc`=8000_0010.
- `halt` high after a handshake → no further `imem_req_valid`. Deasserting `halt` resumes at pc+4.
